// File: rtl/vector_pkg.sv
// Shared definitions for the vector display path: point word layout and
// the frame sequencer state encoding.
package vector_pkg;

    localparam int unsigned COORD_W  = 12;

    // Point word field positions
    localparam int unsigned Y_LSB    = 0;
    localparam int unsigned X_LSB    = 12;
    localparam int unsigned DRAW_BIT = 24;
    localparam int unsigned EOF_BIT  = 31;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StLatch     = 3'd2,
        StIssue     = 3'd3,
        StHold      = 3'd4,
        StWait      = 3'd5,
        StPark      = 3'd6,
        StFrameWait = 3'd7
    } seq_state_e;

endpackage

// File: rtl/frame_timer.sv
// Saturating frame-period counter. Cleared at each frame start; period_met
// rises once PERIOD-1 cycles have elapsed since the clear.
module frame_timer #(
    parameter int unsigned PERIOD = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic period_met
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up and hold at the limit
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign period_met = (count_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Replays the displayed bank of the point buffer into the line drawer, one
// frame per pass, with bank swapping, beam parking and a minimum frame period.
module frame_sequencer
    import vector_pkg::*;
#(
    parameter int unsigned         ADDR_W           = 11,
    parameter int unsigned         MIN_FRAME_CYCLES = 500000,
    parameter logic [COORD_W-1:0]  PARK_X           = 12'd2048,
    parameter logic [COORD_W-1:0]  PARK_Y           = 12'd2048
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               bank,
    output logic [ADDR_W-1:0]  index,
    input  logic [31:0]        point,
    input  logic               ready,
    output logic               draw,
    output logic               jump,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = '1;

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  index_q, index_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               draw_bit_q, draw_bit_d;
    // Set while the park vector is in ISSUE/HOLD/WAIT
    logic               parking_q, parking_d;
    logic               bank_q, bank_d;
    logic               pending_q, pending_d;
    logic               swap_ack_q, swap_ack_d;
    logic               apply_swap;
    logic               timer_clear;
    logic               period_met;

    // Bits between the draw flag and the end marker carry no meaning
    logic unused_point_bits;
    assign unused_point_bits = ^point[EOF_BIT-1:DRAW_BIT+1];

    frame_timer #(
        .PERIOD (MIN_FRAME_CYCLES)
    ) u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (timer_clear),
        .run        (state_q != StIdle),
        .period_met (period_met)
    );

    // Next-state, point latching and bank-swap decisions
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        x_d         = x_q;
        y_d         = y_q;
        draw_bit_d  = draw_bit_q;
        parking_d   = parking_q;
        apply_swap  = 1'b0;
        timer_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && ready) begin
                    state_d     = StFetch;
                    index_d     = '0;
                    timer_clear = 1'b1;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                if (point[EOF_BIT]) begin
                    state_d = StPark;
                end else begin
                    x_d        = point[X_LSB +: COORD_W];
                    y_d        = point[Y_LSB +: COORD_W];
                    draw_bit_d = point[DRAW_BIT];
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                state_d = StHold;
            end
            StHold: begin
                // Drawer lowers ready only one cycle after a pulse
                state_d = StWait;
            end
            StWait: begin
                if (ready) begin
                    if (parking_q) begin
                        parking_d  = 1'b0;
                        apply_swap = pending_q;
                        state_d    = StFrameWait;
                    end else if (!enable || (index_q == LAST_INDEX)) begin
                        state_d = StPark;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StPark: begin
                if (ready) begin
                    x_d        = PARK_X;
                    y_d        = PARK_Y;
                    draw_bit_d = 1'b0;
                    parking_d  = 1'b1;
                    state_d    = StIssue;
                end
            end
            StFrameWait: begin
                if (period_met) begin
                    if (enable) begin
                        state_d     = StFetch;
                        index_d     = '0;
                        timer_clear = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Swap lands on entry to FRAME_WAIT; a request in that same cycle stays pending
        bank_d     = apply_swap ? ~bank_q : bank_q;
        swap_ack_d = apply_swap;
        pending_d  = swap_req | (pending_q & ~apply_swap);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            index_q    <= '0;
            x_q        <= PARK_X;
            y_q        <= PARK_Y;
            draw_bit_q <= 1'b0;
            parking_q  <= 1'b0;
            bank_q     <= 1'b0;
            pending_q  <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            x_q        <= x_d;
            y_q        <= y_d;
            draw_bit_q <= draw_bit_d;
            parking_q  <= parking_d;
            bank_q     <= bank_d;
            pending_q  <= pending_d;
            swap_ack_q <= swap_ack_d;
        end
    end

    // Pulses decode from the registered state so reset removes them at once
    assign draw       = (state_q == StIssue) && draw_bit_q;
    assign jump       = (state_q == StIssue) && !draw_bit_q;
    assign frame_done = (state_q == StIssue) && parking_q;
    assign busy       = (state_q != StIdle);
    assign swap_ack   = swap_ack_q;
    assign bank       = bank_q;
    assign index      = index_q;
    assign x          = x_q;
    assign y          = y_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomised scoreboard bench for frame_sequencer: a frame-level reference
// model predicts every pulse; a monitor compares what the DUT emits.
module tb_frame_sequencer;

    localparam int unsigned ADDR_W   = 4;
    localparam int          DEPTH    = 16;
    localparam int          MIN_FC   = 120;
    localparam logic [11:0] PARK     = 12'd2048;
    localparam int          FD_BOUND = 1000;

    typedef enum int {EvDraw, EvJump, EvPark, EvSwap} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [11:0] ex;
        logic [11:0] ey;
        int          idx;
        logic        bk;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable;
    logic              swap_req;
    logic              swap_ack;
    logic              bank;
    logic [ADDR_W-1:0] index;
    logic [31:0]       point;
    logic              ready = 1'b1;
    logic              draw;
    logic              jump;
    logic [11:0]       x;
    logic [11:0]       y;
    logic              busy;
    logic              frame_done;

    logic [31:0] mem [2][DEPTH];
    ev_t         sb[$];
    logic        model_bank;
    int          checks = 0;
    int          passes = 0;

    frame_sequencer #(
        .ADDR_W           (ADDR_W),
        .MIN_FRAME_CYCLES (MIN_FC),
        .PARK_X           (PARK),
        .PARK_Y           (PARK)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .enable     (enable),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .bank       (bank),
        .index      (index),
        .point      (point),
        .ready      (ready),
        .draw       (draw),
        .jump       (jump),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Point buffer: one cycle read latency, bank selects the upper half
    always @(posedge clk) point <= mem[bank][index];

    // Drawer model: ready drops the cycle after a pulse for 1..10 cycles
    int ready_cnt = 0;
    always @(posedge clk) begin
        if (draw || jump) begin
            ready     <= 1'b0;
            ready_cnt <= int'($urandom_range(10, 1));
        end else if (ready_cnt > 1) begin
            ready_cnt <= ready_cnt - 1;
        end else begin
            ready     <= 1'b1;
            ready_cnt <= 0;
        end
    end

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // Expected pulses for one pass over a bank; limit>0 truncates after that many points
    task automatic push_frame(input logic bk, input int limit);
        ev_t e;
        int  park_idx;
        park_idx = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[bk][i][31]) begin
                park_idx = i;
                break;
            end
            e.kind = mem[bk][i][24] ? EvDraw : EvJump;
            e.ex   = mem[bk][i][23:12];
            e.ey   = mem[bk][i][11:0];
            e.idx  = i;
            e.bk   = bk;
            sb.push_back(e);
            if (i + 1 == limit) begin
                park_idx = i;
                break;
            end
        end
        e.kind = EvPark;
        e.ex   = PARK;
        e.ey   = PARK;
        e.idx  = park_idx;
        e.bk   = bk;
        sb.push_back(e);
    endtask

    task automatic write_directed(input logic bk);
        mem[bk][0] = {7'd0, 1'b0, 12'd100, 12'd100};
        mem[bk][1] = {7'd0, 1'b1, 12'd200, 12'd100};
        mem[bk][2] = {7'd0, 1'b1, 12'd200, 12'd200};
        mem[bk][3] = 32'h8000_0000;
        for (int i = 4; i < DEPTH; i++) mem[bk][i] = $urandom;
    endtask

    task automatic write_frame(input logic bk, input int len);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < len) begin
                mem[bk][i] = {1'b0, 6'($urandom), 1'($urandom), 12'($urandom), 12'($urandom)};
            end else if (i == len) begin
                mem[bk][i] = {1'b1, 31'($urandom)};
            end else begin
                mem[bk][i] = $urandom;
            end
        end
    endtask

    function automatic int rand_len();
        int r;
        r = int'($urandom_range(3, 0));
        if (r == 0) return 0;
        if (r == 1) return DEPTH;
        return int'($urandom_range(DEPTH - 1, 1));
    endfunction

    // Fill the hidden bank and request a swap; len<0 loads the directed frame
    task automatic do_swap(input int len);
        ev_t  e;
        logic nb;
        nb = ~model_bank;
        if (len < 0) write_directed(nb);
        else write_frame(nb, len);
        e.kind = EvSwap;
        e.ex   = '0;
        e.ey   = '0;
        e.idx  = 0;
        e.bk   = nb;
        sb.push_back(e);
        model_bank = nb;
        swap_req   = 1'b1;
        @(posedge clk);
        #1 swap_req = 1'b0;
    endtask

    task automatic wait_fd();
        for (int i = 0; i < FD_BOUND; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        check(1'b0, "frame_done_timeout", $sformatf("no frame_done within %0d cycles", FD_BOUND));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < MIN_FC + 100; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
    endtask

    // Monitor: pop and compare on every pulse, and time back-to-back empty frames
    int       cyc = 0;
    int       pts = 0;
    int       prev_fd = 0;
    bit       prev_valid = 0;
    bit       prev_empty = 0;
    always @(negedge clk) begin
        ev_t      exp_ev;
        ev_kind_e act;
        bit       ok;
        cyc++;
        if (rst || !busy) begin
            prev_valid = 0;
            pts = 0;
        end
        if (!rst && (draw || jump || swap_ack || frame_done)) begin
            if (swap_ack) act = EvSwap;
            else if (draw) act = EvDraw;
            else if (frame_done) act = EvPark;
            else act = EvJump;
            if (draw || jump) begin
                check(!(draw && jump) && ready, "pulse_legal",
                      $sformatf("draw=%0b jump=%0b ready=%0b, need one pulse with ready=1",
                                draw, jump, ready));
            end
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_event", $sformatf("got kind=%0d x=%0d y=%0d idx=%0d, none expected",
                                                          act, x, y, index));
            end else begin
                exp_ev = sb.pop_front();
                if (exp_ev.kind == EvSwap) begin
                    ok = (act == EvSwap) && (bank == exp_ev.bk);
                end else begin
                    ok = (act == exp_ev.kind) && (x == exp_ev.ex) && (y == exp_ev.ey) &&
                         (int'(index) == exp_ev.idx) && (bank == exp_ev.bk) &&
                         (frame_done == (exp_ev.kind == EvPark)) && !(draw && frame_done);
                end
                check(ok, "event", $sformatf(
                    "got kind=%0d x=%0d y=%0d idx=%0d bank=%0b fd=%0b, need kind=%0d x=%0d y=%0d idx=%0d bank=%0b",
                    act, x, y, index, bank, frame_done,
                    exp_ev.kind, exp_ev.ex, exp_ev.ey, exp_ev.idx, exp_ev.bk));
            end
            if (act == EvPark) begin
                if (prev_valid && prev_empty && pts == 0) begin
                    check(cyc - prev_fd == MIN_FC, "empty_period",
                          $sformatf("got %0d cycles, need %0d", cyc - prev_fd, MIN_FC));
                end
                prev_valid = 1;
                prev_empty = (pts == 0);
                prev_fd    = cyc;
                pts        = 0;
            end else if (act != EvSwap) begin
                pts++;
            end
        end
    end

    initial begin
        int n;
        enable     = 1'b0;
        swap_req   = 1'b0;
        model_bank = 1'b0;
        write_directed(1'b0);
        write_frame(1'b1, 0);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check(bank == 1'b0 && index == '0, "reset_addr", $sformatf("got bank=%0b index=%0d, need 0/0", bank, index));
        check(x == PARK && y == PARK, "reset_xy", $sformatf("got x=%0d y=%0d, need 2048/2048", x, y));
        check(!draw && !jump && !frame_done && !swap_ack, "reset_pulses",
              $sformatf("got draw=%0b jump=%0b fd=%0b ack=%0b, need 0", draw, jump, frame_done, swap_ack));
        check(!busy, "reset_busy", $sformatf("got busy=%0b, need 0", busy));

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check(!busy && index == '0, "idle_hold", $sformatf("got busy=%0b index=%0d, need 0/0", busy, index));

        // Directed 3-point frame, then a run of random frames and swaps
        push_frame(1'b0, 0);
        enable = 1'b1;
        wait_fd();
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(1, 0) == 1) do_swap(rand_len());
            push_frame(model_bank, 0);
            wait_fd();
        end

        // Back-to-back empty frames, ending on bank 0
        do begin
            do_swap(0);
            push_frame(model_bank, 0);
            wait_fd();
        end while (model_bank != 1'b0);
        repeat (2) begin
            push_frame(model_bank, 0);
            wait_fd();
        end

        // Directed frame on bank 1; enable drops after the second vector
        do_swap(-1);
        push_frame(model_bank, 2);
        n = 0;
        for (int i = 0; i < FD_BOUND && n < 2; i++) begin
            @(negedge clk);
            if ((draw || jump) && !frame_done) n++;
        end
        check(n == 2, "second_vector", $sformatf("got %0d vectors, need 2", n));
        @(negedge clk);
        enable = 1'b0;
        wait_fd();
        wait_idle();
        check(!busy && index == 4'd1, "enable_drop",
              $sformatf("got busy=%0b index=%0d, need 0/1", busy, index));

        // Reset while a draw is being issued from bank 1
        write_directed(1'b0);
        push_frame(model_bank, 0);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < FD_BOUND; i++) begin
            @(negedge clk);
            if (draw) begin
                n = 1;
                break;
            end
        end
        check(n == 1 && bank == 1'b1, "draw_before_reset",
              $sformatf("got draw_seen=%0d bank=%0b, need 1/1", n, bank));
        #1 rst = 1'b1;
        #1;
        check(!draw && !jump && !busy, "reset_mid_issue",
              $sformatf("got draw=%0b jump=%0b busy=%0b, need 0", draw, jump, busy));
        check(x == PARK && y == PARK && bank == 1'b0 && index == '0, "reset_mid_state",
              $sformatf("got x=%0d y=%0d bank=%0b index=%0d, need 2048/2048/0/0", x, y, bank, index));
        sb.delete();
        model_bank = 1'b0;
        push_frame(1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_fd();
        enable = 1'b0;
        wait_idle();
        check(!busy, "final_idle", $sformatf("got busy=%0b, need 0", busy));
        check(sb.size() == 0, "scoreboard_drained", $sformatf("got %0d pending, need 0", sb.size()));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Replays a stored display list, one frame per pass, into the vector line-drawing controller (`control`): fetches 32-bit point words from the point buffer, issues one draw/jump per point, and honours the `ready` handshake.
- Adds three things: double-buffer bank swap at frame boundaries, beam parking between frames, and a minimum frame period for refresh-rate limiting.
- Sits between `rx_buffer` (point memory) and `control`, replacing the single-point fetch logic in the top level.

Parameters:
- ADDR_W, 11, point index width; one bank holds 2^ADDR_W words.
- MIN_FRAME_CYCLES, 500000, minimum clocks from frame start to next frame start (100 Hz at 50 MHz).
- PARK_X, 12'd2048, beam X parked between frames.
- PARK_Y, 12'd2048, beam Y parked between frames.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = run frames, 0 = finish current vector, park, idle
- swap_req  in  1  1-cycle pulse: the inactive bank holds a complete new frame
- swap_ack  out  1  1-cycle pulse when the bank swap is applied
- bank  out  1  bank currently being displayed
- index  out  ADDR_W  read address into the point buffer
- point  in  32  buffer read data, valid 1 cycle after index; [11:0] y, [23:12] x, [24] 1=draw 0=jump, [31] end-of-frame marker (word not drawn)
- ready  in  1  line drawer idle
- draw  out  1  1-cycle pulse: line from the current position to x,y
- jump  out  1  1-cycle pulse: blanked move to x,y
- x  out  12  target X, stable from the pulse until the next pulse
- y  out  12  target Y, same timing as x
- busy  out  1  high in every state except IDLE
- frame_done  out  1  1-cycle pulse when the park move is issued

Behaviour:
- Reset values: state IDLE; all pulses 0; bank=0; index=0; x=PARK_X; y=PARK_Y; frame counter=0; swap pending=0.
- FSM states: IDLE, FETCH, LATCH, ISSUE, HOLD, WAIT, PARK, FRAME_WAIT.
- IDLE: when enable=1 and ready=1 → FETCH with index=0 and the frame counter cleared.
- FETCH: index is driven; go to LATCH after 1 cycle (read latency).
- LATCH, point[31]=1: end of frame → PARK.
- LATCH, point[31]=0: register x, y and the draw/jump bit → ISSUE.
- ISSUE: assert draw if bit24=1, else jump, for exactly 1 cycle → HOLD.
- HOLD: ignore ready for 1 cycle (the drawer drops ready the cycle after a pulse) → WAIT.
- WAIT: when ready=1, index+1 → FETCH.
  - Exception: if index was 2^ADDR_W-1, no wrap; treat as end of frame → PARK.
  - Exception: if enable=0, → PARK.
- PARK: once ready=1, issue jump to PARK_X,PARK_Y and pulse frame_done. The drawer then gets the same 1-cycle HOLD and wait-for-ready as a point, after which → FRAME_WAIT.
- FRAME_WAIT:
  - Apply a pending swap: toggle bank, pulse swap_ack, clear pending.
  - Wait until the frame counter ≥ MIN_FRAME_CYCLES-1.
  - Then → FETCH with index=0 and the counter cleared if enable=1; otherwise → IDLE.
- Frame counter: saturating, increments every cycle outside IDLE, sized for MIN_FRAME_CYCLES.
- Frame longer than MIN_FRAME_CYCLES: the next frame starts immediately after park; no error is raised.
- Empty frame (word 0 has the marker): only the park jump and frame_done occur.
- swap_req pulse sets pending. A pulse arriving in the same cycle as the apply leaves pending set and is applied at the next boundary. Bank never changes mid-frame.
- Pulses: draw and jump are never asserted together. No pulse is issued while ready=0, except the ignored HOLD window.
- Reset asserted mid-frame: everything clears immediately. A partially issued vector is abandoned. The first frame after reset starts at bank 0, index 0.

Decomposition:
- Shared package `vector_pkg`:
  - point field positions: Y_LSB=0, X_LSB=12, DRAW_BIT=24, EOF_BIT=31
  - COORD_W=12
  - state enum encoding
- One natural sub-module: `frame_timer`, the saturating period counter with clear and a `period_met` output.

Test Plan:
- 3-point frame (jump 100,100; draw 200,100; draw 200,200; EOF), drawer ready after 10 cycles → pulses jump, draw, draw with matching x/y, then a park jump to 2048,2048 and a frame_done pulse; index sequence 0,1,2,3.
- MIN_FRAME_CYCLES=1000, short frame → the second frame's first FETCH occurs exactly 1000 cycles after the first frame's FETCH.
- swap_req mid-frame → bank stays 0 until FRAME_WAIT, then swap_ack and bank=1; the next frame reads bank 1 from index 0.
- Empty frame (word0 = 0x80000000) → no draw/jump except the park jump; frame_done fires once per period.
- enable dropped during the second vector's WAIT → the vector completes, park is issued, state goes to IDLE, busy=0, and index 2 is never fetched.
- reset asserted while in ISSUE → draw is cleared in the same cycle; x,y return to 2048,2048 and bank to 0; normal restart follows deassertion.
